mic_xcorr_array: RTL and testbench
==================================

Name: mic_xcorr_array

Overview:
Multi-channel time-delay estimator for the microphone array. It captures one frame of already-decoded, clock-domain-synchronised PCM samples from CH_NUM microphones. For every channel c ≥ 1 it computes the time-domain cross-correlation against reference channel 0 over lags −LAGNUM..+LAGNUM, and reports the lag of the absolute peak, the peak magnitude and a confidence flag. It sits between the I2S decoder/CDC stage and the beamforming/localisation logic, and supersedes the fixed two-channel subsystem with a single-clock, parametrised design that supports continuous mode.

Parameters:
- CH_NUM, 4, number of microphone channels (≥ 2); channel 0 is the reference.
- DW, 16, signed sample width.
- FRAME_LEN, 512, samples per channel per frame (power of 2, ≥ 16).
- LAGNUM, 10, maximum absolute lag searched (1 ≤ LAGNUM < FRAME_LEN/2).
- MIN_PEAK, 0, unsigned peak threshold; a peak ≤ MIN_PEAK is flagged invalid.
- Derived: AW = 2*DW + clog2(FRAME_LEN); LW = clog2(LAGNUM+1) + 1 (signed).

Ports:
- clk_60MHz  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a capture+compute cycle.
- cont_mode  in  1  1 = rearm automatically after each result.
- smp_valid  in  1  one strobe per sample instant, all channels aligned.
- smp_data  in  CH_NUM*DW  packed signed samples; channel c occupies [c*DW +: DW].
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when results update.
- lag_diff  out  (CH_NUM-1)*LW  signed peak lag per channel 1..CH_NUM-1.
- peak_mag  out  (CH_NUM-1)*AW  unsigned |r| at the peak.
- lag_valid  out  CH_NUM-1  1 when peak_mag > MIN_PEAK.
- overrun  out  1  sticky; set when smp_valid arrives while in CALC/DRAIN/UPDATE; cleared by start or rst.

Behaviour:
- Reset (rst=1 on clk edge): state IDLE. busy, done, overrun, lag_valid and every lag_diff and peak_mag field are 0. Buffer contents are don't-care.
- FSM states:
  - IDLE: start → CAPTURE. busy=0.
  - CAPTURE: each smp_valid writes all CH_NUM samples at wr_addr, then wr_addr increments. On the write with wr_addr = FRAME_LEN−1 → CALC on the next cycle.
  - CALC: for channel c=1..CH_NUM-1 (outer loop), k = −LAGNUM..+LAGNUM, n = 0..FRAME_LEN−1, issue one address pair per cycle: x0[n], xc[n+k]. If n+k is outside 0..FRAME_LEN−1, the product is forced to 0 (zero padding; the cycle is still spent). The accumulator is cleared at n=0.
  - DRAIN: 2 cycles to flush RAM read (1 cycle) and multiply (1 cycle).
  - UPDATE: 1 cycle. Compute |acc| and compare against the running max for channel c. Use a strict > comparison, so on ties the most negative lag wins. The first lag (k=−LAGNUM) always loads. Then advance k or c: → CALC; after the last (c, k) → OUTPUT.
  - OUTPUT: 1 cycle. Register all results, pulse done, set lag_valid. Then → CAPTURE if cont_mode=1, else → IDLE.
- Correlation: r_c(k) = Σ x0[n]·xc[n+k]. Positive k means channel c arrives later than ref. Products are signed 2DW; the accumulator is signed AW and cannot overflow by construction. abs() of the AW value needs no saturation.
- Latency: done pulses exactly (CH_NUM−1)·(2·LAGNUM+1)·(FRAME_LEN+3)+1 cycles after the clock that accepted the last sample.
- start while busy: ignored. start asserted in the same cycle as the IDLE → CAPTURE entry: counted once.
- smp_valid in IDLE/OUTPUT: ignored. smp_valid in CALC/DRAIN/UPDATE: ignored and overrun set. In continuous mode, capture restarts at wr_addr 0.
- Outputs hold their last values between done pulses; they change only in OUTPUT.
- rst mid-CAPTURE or mid-CALC: immediate return to IDLE, and all outputs go to their reset values.

Decomposition:
- Package mic_array_pkg holds state encoding localparams, the AW/LW derivation function, and the lag-to-signed conversion helper.
- One sub-module, xcorr_mac_lane, holds the multiply, accumulate, clear and zero-pad-gate pipeline: 2-stage, inputs are a valid/clear/last tag and operands, output is acc plus an acc_valid pulse.
- Sample buffers are inferred simple dual-port RAM inside the top, one per channel, with 1-cycle read.

Test Plan (sim params CH_NUM=3, DW=16, FRAME_LEN=64, LAGNUM=4, MIN_PEAK=0 unless noted):
1. Reset mid-CALC → next cycle busy=0, done=0, lag_diff=0, lag_valid=0. A following start gives a full normal run.
2. ch0 = pseudo-random noise, ch1 = ch0 delayed by 3 samples, ch2 = ch0 advanced by 2 → lag_diff = {ch1:+3, ch2:−2}, lag_valid=2'b11, done pulses exactly 2·9·67+1 = 1207 cycles after the 64th sample.
3. ch1 = −ch0 (inverted), no delay → lag_diff[ch1]=0 (abs peak), peak_mag[ch1] = Σ ch0² exactly.
4. All channels zero, MIN_PEAK=0 → every peak_mag=0, lag_valid=0, lag_diff=−4 (first lag, strict-compare tie rule).
5. cont_mode=1, two frames with delays +1 then −4 → two done pulses, lag_diff follows +1 then −4. smp_valid during CALC sets overrun=1, which stays set until the next start.
6. start pulsed while busy, and smp_valid asserted in IDLE → no effect: wr_addr unchanged, single done per run.

Source files
------------

// File: rtl/mic_array_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mic_array_pkg
// Description : Shared constants and helpers for the microphone-array
//               cross-correlation delay estimator.
// Revision    : 1.0 - initial release
// ============================================================================
package mic_array_pkg;

  // Controller state encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CAPTURE = 3'd1;
  localparam logic [2:0] ST_CALC    = 3'd2;
  localparam logic [2:0] ST_DRAIN   = 3'd3;
  localparam logic [2:0] ST_UPDATE  = 3'd4;
  localparam logic [2:0] ST_OUTPUT  = 3'd5;

  // Accumulator width: full-precision product plus one bit per doubling of frame length
  function automatic int acc_width(input int dw, input int frame_len);
    return 2 * dw + $clog2(frame_len);
  endfunction

  // Signed lag width able to hold -lagnum..+lagnum
  function automatic int lag_width(input int lagnum);
    return $clog2(lagnum + 1) + 1;
  endfunction

  // Lag index 0..2*lagnum maps to signed lag -lagnum..+lagnum
  function automatic int lag_of_index(input int idx, input int lagnum);
    return idx - lagnum;
  endfunction

endpackage
`default_nettype wire

// File: rtl/xcorr_mac_lane.sv
`default_nettype none
// ============================================================================
// Module      : xcorr_mac_lane
// Description : Two-stage multiply/accumulate lane. Stage 1 registers the
//               gated signed product, stage 2 clears or accumulates it and
//               flags the final term of a sum with acc_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module xcorr_mac_lane #(
  parameter int DW = 16,
  parameter int AW = 38
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid,
  input  logic                 clear,
  input  logic                 last,
  input  logic                 gate,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [AW-1:0] acc,
  output logic                 acc_valid
);

  logic signed [2*DW-1:0] a_ext;
  logic signed [2*DW-1:0] b_ext;
  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   prod_ext;
  logic                   v1;
  logic                   c1;
  logic                   l1;

  assign a_ext    = $signed({{DW{a[DW-1]}}, a});
  assign b_ext    = $signed({{DW{b[DW-1]}}, b});
  assign prod_ext = $signed({{(AW-2*DW){prod[2*DW-1]}}, prod});

  // Stage 1: product, forced to zero for padded (out-of-frame) terms
  always_ff @(posedge clk) begin
    if (rst) begin
      v1   <= 1'b0;
      c1   <= 1'b0;
      l1   <= 1'b0;
      prod <= '0;
    end else begin
      v1   <= valid;
      c1   <= clear;
      l1   <= last;
      prod <= (valid && gate) ? a_ext * b_ext : '0;
    end
  end

  // Stage 2: accumulate, restarting the sum on the first term
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      acc_valid <= 1'b0;
    end else begin
      acc_valid <= v1 && l1;
      if (v1) begin
        acc <= c1 ? prod_ext : acc + prod_ext;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mic_xcorr_array.sv
`default_nettype none
// ============================================================================
// Module      : mic_xcorr_array
// Description : Captures one frame per microphone channel and, for every
//               channel c >= 1, finds the lag in -LAGNUM..+LAGNUM maximising
//               |sum x0[n]*xc[n+k]|, reporting lag, magnitude and validity.
// Revision    : 1.0 - initial release
// ============================================================================
module mic_xcorr_array
  import mic_array_pkg::*;
#(
  parameter int CH_NUM    = 4,
  parameter int DW        = 16,
  parameter int FRAME_LEN = 512,
  parameter int LAGNUM    = 10,
  parameter int MIN_PEAK  = 0,
  localparam int AW       = acc_width(DW, FRAME_LEN),
  localparam int LW       = lag_width(LAGNUM)
) (
  input  logic                       clk_60MHz,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       cont_mode,
  input  logic                       smp_valid,
  input  logic [CH_NUM*DW-1:0]       smp_data,
  output logic                       busy,
  output logic                       done,
  output logic [(CH_NUM-1)*LW-1:0]   lag_diff,
  output logic [(CH_NUM-1)*AW-1:0]   peak_mag,
  output logic [CH_NUM-2:0]          lag_valid,
  output logic                       overrun
);

  localparam int NW   = $clog2(FRAME_LEN);
  localparam int KMAX = 2 * LAGNUM;
  localparam int KW   = $clog2(KMAX + 1);
  localparam int CW   = $clog2(CH_NUM);

  logic [2:0]            state;
  logic [NW-1:0]         wr_addr;
  logic [NW-1:0]         n;
  logic [KW-1:0]         kidx;
  logic [CW-1:0]         c;
  logic [CW-1:0]         ci;
  logic                  drain_cnt;
  int                    pos;
  logic                  pos_ok;
  logic [NW-1:0]         rd_addr_c;
  logic [CH_NUM*DW-1:0]  rd_bus;
  logic                  rd_valid;
  logic                  rd_clear;
  logic                  rd_last;
  logic                  rd_gate;
  logic signed [DW-1:0]  x0_q;
  logic signed [DW-1:0]  xc_q;
  logic signed [AW-1:0]  acc;
  logic                  acc_valid;
  logic [AW-1:0]         acc_abs;
  logic signed [LW-1:0]  cur_lag;
  logic [AW-1:0]         best_mag [CH_NUM-1];
  logic signed [LW-1:0]  best_lag [CH_NUM-1];
  logic [AW-1:0]         out_mag  [CH_NUM-1];
  logic signed [LW-1:0]  out_lag  [CH_NUM-1];

  assign busy    = (state != ST_IDLE);
  assign ci      = c - CW'(1);
  assign cur_lag = LW'(lag_of_index(int'(kidx), LAGNUM));
  assign x0_q    = rd_bus[DW-1:0];
  assign xc_q    = rd_bus[c*DW +: DW];
  assign acc_abs = acc[AW-1] ? -acc : acc;

  // Partner-channel read address n+k and its in-frame check
  always_comb begin
    pos       = int'(n) + int'(kidx) - LAGNUM;
    pos_ok    = (pos >= 0) && (pos < FRAME_LEN);
    rd_addr_c = pos[NW-1:0];
  end

  // One simple dual-port buffer per channel; channel 0 is read at n, the rest at n+k
  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    logic [DW-1:0] mem [FRAME_LEN];
    logic [DW-1:0] rd_q;
    logic [NW-1:0] raddr;
    assign raddr = (g == 0) ? n : rd_addr_c;
    assign rd_bus[g*DW +: DW] = rd_q;

    // Capture write port and registered read port
    always_ff @(posedge clk_60MHz) begin
      if (state == ST_CAPTURE && smp_valid) begin
        mem[wr_addr] <= smp_data[g*DW +: DW];
      end
      rd_q <= mem[raddr];
    end
  end

  // Term tags travel alongside the RAM read so they reach the lane with the data
  always_ff @(posedge clk_60MHz) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_clear <= 1'b0;
      rd_last  <= 1'b0;
      rd_gate  <= 1'b0;
    end else begin
      rd_valid <= (state == ST_CALC);
      rd_clear <= (state == ST_CALC) && (n == '0);
      rd_last  <= (state == ST_CALC) && (n == NW'(FRAME_LEN - 1));
      rd_gate  <= pos_ok;
    end
  end

  xcorr_mac_lane #(
    .DW (DW),
    .AW (AW)
  ) u_lane (
    .clk       (clk_60MHz),
    .rst       (rst),
    .valid     (rd_valid),
    .clear     (rd_clear),
    .last      (rd_last),
    .gate      (rd_gate),
    .a         (x0_q),
    .b         (xc_q),
    .acc       (acc),
    .acc_valid (acc_valid)
  );

  // Control FSM: capture, sweep (channel, lag, n), drain, compare, publish
  always_ff @(posedge clk_60MHz) begin
    if (rst) begin
      state     <= ST_IDLE;
      wr_addr   <= '0;
      n         <= '0;
      kidx      <= '0;
      c         <= CW'(1);
      drain_cnt <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      done <= 1'b0;
      if ((state == ST_CALC || state == ST_DRAIN || state == ST_UPDATE) && smp_valid) begin
        overrun <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_CAPTURE;
            wr_addr <= '0;
            overrun <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          if (smp_valid) begin
            wr_addr <= wr_addr + NW'(1);
            if (wr_addr == NW'(FRAME_LEN - 1)) begin
              state <= ST_CALC;
              n     <= '0;
              kidx  <= '0;
              c     <= CW'(1);
            end
          end
        end
        ST_CALC: begin
          n <= n + NW'(1);
          if (n == NW'(FRAME_LEN - 1)) begin
            state     <= ST_DRAIN;
            drain_cnt <= 1'b0;
          end
        end
        ST_DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) begin
            state <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          n <= '0;
          if (kidx == KW'(KMAX)) begin
            kidx <= '0;
            if (c == CW'(CH_NUM - 1)) begin
              state <= ST_OUTPUT;
            end else begin
              c     <= c + CW'(1);
              state <= ST_CALC;
            end
          end else begin
            kidx  <= kidx + KW'(1);
            state <= ST_CALC;
          end
        end
        ST_OUTPUT: begin
          done    <= 1'b1;
          wr_addr <= '0;
          state   <= cont_mode ? ST_CAPTURE : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Running peak per channel; strict > keeps the most negative lag on ties
  always_ff @(posedge clk_60MHz) begin
    if (state == ST_UPDATE && acc_valid && (kidx == '0 || acc_abs > best_mag[ci])) begin
      best_mag[ci] <= acc_abs;
      best_lag[ci] <= cur_lag;
    end
  end

  // Published results only change when a frame completes
  always_ff @(posedge clk_60MHz) begin
    if (rst) begin
      lag_valid <= '0;
      for (int i = 0; i < CH_NUM - 1; i++) begin
        out_mag[i] <= '0;
        out_lag[i] <= '0;
      end
    end else if (state == ST_OUTPUT) begin
      for (int i = 0; i < CH_NUM - 1; i++) begin
        out_mag[i]   <= best_mag[i];
        out_lag[i]   <= best_lag[i];
        lag_valid[i] <= (best_mag[i] > AW'(MIN_PEAK));
      end
    end
  end

  for (genvar g = 0; g < CH_NUM - 1; g++) begin : g_out
    assign lag_diff[g*LW +: LW] = out_lag[g];
    assign peak_mag[g*AW +: AW] = out_mag[g];
  end

endmodule
`default_nettype wire

// File: tb/tb_mic_xcorr_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_mic_xcorr_array
// Description : Directed self-checking bench for mic_xcorr_array
//               (CH_NUM=3, DW=16, FRAME_LEN=64, LAGNUM=4, MIN_PEAK=0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mic_xcorr_array;

  localparam int CH_NUM    = 3;
  localparam int DW        = 16;
  localparam int FRAME_LEN = 64;
  localparam int LAGNUM    = 4;
  localparam int AW        = 38;
  localparam int LW        = 4;
  localparam int LATENCY   = 1207;

  logic                     clk_60MHz = 1'b0;
  logic                     rst;
  logic                     start;
  logic                     cont_mode;
  logic                     smp_valid;
  logic [CH_NUM*DW-1:0]     smp_data;
  logic                     busy;
  logic                     done;
  logic [(CH_NUM-1)*LW-1:0] lag_diff;
  logic [(CH_NUM-1)*AW-1:0] peak_mag;
  logic [CH_NUM-2:0]        lag_valid;
  logic                     overrun;

  int     checks   = 0;
  int     failures = 0;
  int     cyc      = 0;
  int     done_cnt = 0;
  int     accept_cyc;
  int     done_cyc;
  int     base_cnt;
  int     s [80];
  int     x [3][64];
  longint sq;
  logic [31:0] seed;

  mic_xcorr_array #(
    .CH_NUM    (CH_NUM),
    .DW        (DW),
    .FRAME_LEN (FRAME_LEN),
    .LAGNUM    (LAGNUM),
    .MIN_PEAK  (0)
  ) dut (
    .clk_60MHz (clk_60MHz),
    .rst       (rst),
    .start     (start),
    .cont_mode (cont_mode),
    .smp_valid (smp_valid),
    .smp_data  (smp_data),
    .busy      (busy),
    .done      (done),
    .lag_diff  (lag_diff),
    .peak_mag  (peak_mag),
    .lag_valid (lag_valid),
    .overrun   (overrun)
  );

  always #5 clk_60MHz = ~clk_60MHz;

  always @(posedge clk_60MHz) cyc <= cyc + 1;
  always @(negedge clk_60MHz) if (done) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] lb(input int v);
    return 4'(v);
  endfunction

  // x0[n] = s[n+8]; channel with delay d holds s[n+8-d] so its peak sits at lag +d
  task automatic build(input int d1, input int d2);
    for (int i = 0; i < 64; i++) begin
      x[0][i] = s[i + 8];
      x[1][i] = s[i + 8 - d1];
      x[2][i] = s[i + 8 - d2];
    end
  endtask

  task automatic tick();
    @(posedge clk_60MHz);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_frame(input int start_at);
    for (int i = 0; i < 64; i++) begin
      smp_valid = 1'b1;
      start     = (i == start_at);
      smp_data  = {16'(x[2][i]), 16'(x[1][i]), 16'(x[0][i])};
      tick();
    end
    smp_valid  = 1'b0;
    start      = 1'b0;
    accept_cyc = cyc;
  endtask

  task automatic wait_done(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk_60MHz);
      if (done) begin
        ok = 1'b1;
        done_cyc = cyc;
        break;
      end
    end
    check(tag, 128'(ok), 128'(1'b1));
    tick();
  endtask

  task automatic sum_sq(input int lo, input int hi);
    sq = 0;
    for (int i = lo; i <= hi; i++) sq += longint'(x[0][i]) * longint'(x[0][i]);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cont_mode = 1'b0; smp_valid = 1'b0; smp_data = '0;
    seed = 32'h1234_5678;
    for (int i = 0; i < 80; i++) begin
      seed = seed * 32'd1664525 + 32'd1013904223;
      s[i] = int'($signed(seed[31:16])) >>> 2;
    end
    repeat (3) tick();
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_overrun", 128'(overrun), 128'(0));
    check("rst_lag", 128'(lag_diff), 128'(0));
    check("rst_peak", 128'(peak_mag), 128'(0));
    check("rst_valid", 128'(lag_valid), 128'(0));
    rst = 1'b0;
    tick();

    // ch1 delayed by 3, ch2 advanced by 2
    build(3, -2);
    do_start();
    send_frame(-1);
    wait_done("t2_done_seen");
    check("t2_latency", 128'(done_cyc - accept_cyc), 128'(LATENCY));
    check("t2_lag1", 128'(lag_diff[3:0]), 128'(lb(3)));
    check("t2_lag2", 128'(lag_diff[7:4]), 128'(lb(-2)));
    check("t2_valid", 128'(lag_valid), 128'(2'b11));
    sum_sq(0, 60);
    check("t2_peak1", 128'(peak_mag[37:0]), 128'(sq));
    sum_sq(2, 63);
    check("t2_peak2", 128'(peak_mag[75:38]), 128'(sq));

    // reset in the middle of the correlation sweep
    do_start();
    send_frame(-1);
    repeat (200) tick();
    check("t1_busy_mid", 128'(busy), 128'(1));
    rst = 1'b1;
    tick();
    check("t1_busy", 128'(busy), 128'(0));
    check("t1_done", 128'(done), 128'(0));
    check("t1_lag", 128'(lag_diff), 128'(0));
    check("t1_valid", 128'(lag_valid), 128'(0));
    check("t1_peak", 128'(peak_mag), 128'(0));
    rst = 1'b0;
    tick();
    do_start();
    send_frame(-1);
    wait_done("t1_done_seen");
    check("t1_latency", 128'(done_cyc - accept_cyc), 128'(LATENCY));
    check("t1_lag1", 128'(lag_diff[3:0]), 128'(lb(3)));
    check("t1_lag2", 128'(lag_diff[7:4]), 128'(lb(-2)));

    // inverted channel: absolute peak at lag 0
    build(0, 0);
    for (int i = 0; i < 64; i++) x[1][i] = -x[0][i];
    do_start();
    send_frame(-1);
    wait_done("t3_done_seen");
    sum_sq(0, 63);
    check("t3_lag1", 128'(lag_diff[3:0]), 128'(lb(0)));
    check("t3_peak1", 128'(peak_mag[37:0]), 128'(sq));
    check("t3_lag2", 128'(lag_diff[7:4]), 128'(lb(0)));

    // all-zero input: first lag wins, nothing valid
    for (int i = 0; i < 64; i++) begin
      x[0][i] = 0; x[1][i] = 0; x[2][i] = 0;
    end
    do_start();
    send_frame(-1);
    wait_done("t4_done_seen");
    check("t4_peak", 128'(peak_mag), 128'(0));
    check("t4_valid", 128'(lag_valid), 128'(0));
    check("t4_lag1", 128'(lag_diff[3:0]), 128'(lb(-4)));
    check("t4_lag2", 128'(lag_diff[7:4]), 128'(lb(-4)));

    // continuous mode, two frames, overrun from a stray sample during the sweep
    base_cnt  = done_cnt;
    cont_mode = 1'b1;
    build(1, 1);
    do_start();
    send_frame(-1);
    repeat (10) tick();
    check("t5_ovr_before", 128'(overrun), 128'(0));
    smp_valid = 1'b1;
    tick();
    smp_valid = 1'b0;
    check("t5_ovr_set", 128'(overrun), 128'(1));
    wait_done("t5_done_a");
    check("t5_lag1_a", 128'(lag_diff[3:0]), 128'(lb(1)));
    check("t5_lag2_a", 128'(lag_diff[7:4]), 128'(lb(1)));
    check("t5_busy_rearm", 128'(busy), 128'(1));
    build(-4, -4);
    send_frame(-1);
    cont_mode = 1'b0;
    wait_done("t5_done_b");
    check("t5_lag1_b", 128'(lag_diff[3:0]), 128'(lb(-4)));
    check("t5_lag2_b", 128'(lag_diff[7:4]), 128'(lb(-4)));
    check("t5_done_cnt", 128'(done_cnt - base_cnt), 128'(2));
    check("t5_ovr_sticky", 128'(overrun), 128'(1));
    check("t5_idle", 128'(busy), 128'(0));

    // samples while idle and start while busy are ignored
    for (int i = 0; i < 5; i++) begin
      smp_valid = 1'b1;
      smp_data  = {3{16'h7abc}};
      tick();
    end
    smp_valid = 1'b0;
    check("t6_idle_busy", 128'(busy), 128'(0));
    base_cnt = done_cnt;
    build(2, -1);
    do_start();
    check("t6_ovr_clr", 128'(overrun), 128'(0));
    send_frame(30);
    repeat (20) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t6_done_seen");
    check("t6_lag1", 128'(lag_diff[3:0]), 128'(lb(2)));
    check("t6_lag2", 128'(lag_diff[7:4]), 128'(lb(-1)));
    repeat (100) tick();
    check("t6_single_done", 128'(done_cnt - base_cnt), 128'(1));
    check("t6_busy_end", 128'(busy), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
